bist_signature_checker: RTL



---
 rtl/bist_signature_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/bist_signature_checker.sv
// MISR response compactor with sticky pass/fail verdict for the BIST flow.
// Define BIST_SHIFT_COUNT_EN to also require the exact compaction count.
module bist_signature_checker #(
  parameter int              WIDTH      = 16,
  parameter int              RESP_W     = 16,
  parameter logic [WIDTH-1:0] POLY      = 16'h1021,
  parameter logic [WIDTH-1:0] SEED      = 16'hFFFF,
  parameter logic [WIDTH-1:0] GOLDEN    = 16'h0000,
  parameter int              EXP_SHIFTS = 6000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init,
  input  logic              mode,
  input  logic              running,
  input  logic              finish,
  input  logic [RESP_W-1:0] resp,
  output logic [WIDTH-1:0]  signature,
  output logic              done,
  output logic              pass,
  output logic              fail
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COMPACT,
    COMPARE,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [WIDTH-1:0] resp_ext;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;
  logic             match;

  assign resp_ext = WIDTH'(resp);

  // Galois step: taps fold in when the bit shifted out is 1
  assign sig_d = {sig_q[WIDTH-2:0], 1'b0}
               ^ (sig_q[WIDTH-1] ? POLY : '0)
               ^ resp_ext;

`ifdef BIST_SHIFT_COUNT_EN
  localparam int CNT_W = $clog2(EXP_SHIFTS + 1) + 1;
  logic [CNT_W-1:0] cnt_q;

  // Saturating count keeps a very long run from wrapping onto EXP_SHIFTS
  assign match = (sig_q == GOLDEN)
              && (cnt_q == CNT_W'(EXP_SHIFTS));
`else
  assign match = (sig_q == GOLDEN);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef BIST_SHIFT_COUNT_EN
      cnt_q   <= '0;
`endif
    end else if (init) begin
      state_q <= ARMED;
      sig_q   <= SEED;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef BIST_SHIFT_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ARMED, COMPACT: begin
          if (finish) begin
            state_q <= COMPARE;
          end else if (running && mode) begin
            state_q <= COMPACT;
            sig_q   <= sig_d;
`ifdef BIST_SHIFT_COUNT_EN
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        COMPARE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          pass_q  <= match;
          fail_q  <= !match;
        end
        default: ;
      endcase
    end
  end

  assign signature = sig_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule
